// File: rtl/ahb_burst_addr_gen_if.sv
// Command and AHB address-phase signals of the burst address generator.
// The master modport is the generator; the slave modport is its environment.
interface ahb_burst_addr_gen_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [2:0]            cmd_burst;
  logic [2:0]            cmd_size;
  logic [7:0]            cmd_len;
  logic                  busy_req;
  logic                  HREADY;
  logic                  HRESP;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic [2:0]            HBURST;
  logic [2:0]            HSIZE;
  logic [7:0]            beat_idx;
  logic                  burst_done;
  logic                  err_abort;
  logic                  cmd_err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_len, busy_req, HREADY, HRESP,
    output cmd_ready, HADDR, HTRANS, HBURST, HSIZE, beat_idx, burst_done, err_abort, cmd_err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_len, busy_req, HREADY, HRESP,
    input  cmd_ready, HADDR, HTRANS, HBURST, HSIZE, beat_idx, burst_done, err_abort, cmd_err
  );
endinterface

// File: rtl/ahb_burst_addr_gen.sv
// AHB master address-phase sequencer: one burst command in, registered HADDR/HTRANS beats out.
// Beat 0 appears the cycle after acceptance; HREADY=0 holds the beat, two-cycle ERROR aborts.
module ahb_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BOUNDARY   = 1024
) (
  input logic                  HCLK,
  input logic                  HRESET,
  ahb_burst_addr_gen_if.master bus
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam int BND_BITS = $clog2(BOUNDARY);

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  typedef enum logic [2:0] {
    B_SINGLE = 3'd0, B_INCR   = 3'd1, B_WRAP4  = 3'd2, B_INCR4  = 3'd3,
    B_WRAP8  = 3'd4, B_INCR8  = 3'd5, B_WRAP16 = 3'd6, B_INCR16 = 3'd7
  } ahb_burst_e;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BUSY} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic [1:0]            htrans_q;
  ahb_burst_e            hburst_q;
  logic [2:0]            hsize_q;
  logic [7:0]            beat_idx_q;
  logic [7:0]            last_idx_q;
  logic                  wrap_q;
  logic [3:0]            wbits_q;
  logic                  cmd_ready_q;
  logic                  burst_done_q;
  logic                  err_abort_q;
  logic                  cmd_err_q;

  // Command decode
  logic [7:0]            cmd_last_d;
  logic                  cmd_wrap_d;
  logic                  cmd_fixed_d;
  logic [3:0]            cmd_wbits_d;
  logic [ADDR_WIDTH:0]   span_d;
  logic [ADDR_WIDTH:0]   last_byte_d;
  logic                  cross_d;
  logic                  size_bad_d;
  logic                  align_bad_d;
  logic                  cmd_bad_d;

  always_comb begin
    cmd_last_d  = 8'd0;
    cmd_wrap_d  = 1'b0;
    cmd_fixed_d = 1'b0;
    cmd_wbits_d = 4'd0;
    case (ahb_burst_e'(bus.cmd_burst))
      B_INCR:   cmd_last_d = bus.cmd_len;
      B_WRAP4:  begin cmd_last_d = 8'd3;  cmd_wrap_d  = 1'b1; cmd_wbits_d = {1'b0, bus.cmd_size} + 4'd2; end
      B_INCR4:  begin cmd_last_d = 8'd3;  cmd_fixed_d = 1'b1; end
      B_WRAP8:  begin cmd_last_d = 8'd7;  cmd_wrap_d  = 1'b1; cmd_wbits_d = {1'b0, bus.cmd_size} + 4'd3; end
      B_INCR8:  begin cmd_last_d = 8'd7;  cmd_fixed_d = 1'b1; end
      B_WRAP16: begin cmd_last_d = 8'd15; cmd_wrap_d  = 1'b1; cmd_wbits_d = {1'b0, bus.cmd_size} + 4'd4; end
      B_INCR16: begin cmd_last_d = 8'd15; cmd_fixed_d = 1'b1; end
      default:  cmd_last_d = 8'd0;
    endcase
  end

  // The extra top bit catches a fixed burst running off the end of the address space.
  assign span_d      = (ADDR_WIDTH+1)'({1'b0, cmd_last_d} + 9'd1) << bus.cmd_size;
  assign last_byte_d = {1'b0, bus.cmd_addr} + span_d - (ADDR_WIDTH+1)'(1);
  assign cross_d     = cmd_fixed_d &&
                       ((last_byte_d >> BND_BITS) != ({1'b0, bus.cmd_addr} >> BND_BITS));
  assign size_bad_d  = bus.cmd_size > 3'(MAX_SIZE);
  assign align_bad_d = |(bus.cmd_addr & ~({ADDR_WIDTH{1'b1}} << bus.cmd_size));
  assign cmd_bad_d   = size_bad_d | align_bad_d | cross_d;

  // Next beat address
  logic [ADDR_WIDTH-1:0] inc_d;
  logic [ADDR_WIDTH-1:0] sum_d;
  logic [ADDR_WIDTH-1:0] wmask_d;
  logic [ADDR_WIDTH-1:0] nxt_addr_d;
  logic [1:0]            nxt_trans_d;
  logic [1:0]            rsm_trans_d;
  logic                  last_beat_d;

  assign inc_d       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << hsize_q;
  assign sum_d       = haddr_q + inc_d;
  assign wmask_d     = ~({ADDR_WIDTH{1'b1}} << wbits_q);
  assign nxt_addr_d  = wrap_q ? ((haddr_q & ~wmask_d) | (sum_d & wmask_d)) : sum_d;
  // Undefined-length INCR restarts with NONSEQ at each boundary it crosses.
  assign nxt_trans_d = (hburst_q == B_INCR && nxt_addr_d[BND_BITS-1:0] == '0) ? T_NONSEQ : T_SEQ;
  assign rsm_trans_d = (hburst_q == B_INCR && haddr_q[BND_BITS-1:0] == '0) ? T_NONSEQ : T_SEQ;
  assign last_beat_d = beat_idx_q == last_idx_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= S_IDLE;
      haddr_q      <= '0;
      htrans_q     <= T_IDLE;
      hburst_q     <= B_SINGLE;
      hsize_q      <= 3'd0;
      beat_idx_q   <= 8'd0;
      last_idx_q   <= 8'd0;
      wrap_q       <= 1'b0;
      wbits_q      <= 4'd0;
      cmd_ready_q  <= 1'b1;
      burst_done_q <= 1'b0;
      err_abort_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      err_abort_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (cmd_bad_d) begin
              cmd_err_q <= 1'b1;
            end else begin
              haddr_q     <= bus.cmd_addr;
              htrans_q    <= T_NONSEQ;
              hburst_q    <= ahb_burst_e'(bus.cmd_burst);
              hsize_q     <= bus.cmd_size;
              beat_idx_q  <= 8'd0;
              last_idx_q  <= cmd_last_d;
              wrap_q      <= cmd_wrap_d;
              wbits_q     <= cmd_wbits_d;
              cmd_ready_q <= 1'b0;
              state_q     <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (bus.HRESP && !bus.HREADY) begin
            htrans_q    <= T_IDLE;
            err_abort_q <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (bus.HREADY) begin
            if (last_beat_d) begin
              htrans_q     <= T_IDLE;
              burst_done_q <= 1'b1;
              cmd_ready_q  <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              haddr_q    <= nxt_addr_d;
              beat_idx_q <= beat_idx_q + 8'd1;
              if (bus.busy_req) begin
                htrans_q <= T_BUSY;
                state_q  <= S_BUSY;
              end else begin
                htrans_q <= nxt_trans_d;
              end
            end
          end
        end
        S_BUSY: begin
          if (bus.HRESP && !bus.HREADY) begin
            htrans_q    <= T_IDLE;
            err_abort_q <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (bus.HREADY && !bus.busy_req) begin
            htrans_q <= rsm_trans_d;
            state_q  <= S_ADDR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.HADDR      = haddr_q;
  assign bus.HTRANS     = htrans_q;
  assign bus.HBURST     = hburst_q;
  assign bus.HSIZE      = hsize_q;
  assign bus.beat_idx   = beat_idx_q;
  assign bus.burst_done = burst_done_q;
  assign bus.err_abort  = err_abort_q;
  assign bus.cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// Directed bench: expected beats are queued at command issue; a negedge monitor pops and compares.
module tb_ahb_burst_addr_gen;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_burst_addr_gen_if #(.ADDR_WIDTH(32)) bus ();

  ahb_burst_addr_gen #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BOUNDARY  (1024)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  localparam logic [1:0] IDL = 2'd0, BSY = 2'd1, NS = 2'd2, SQ = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [7:0]  idx;
    logic [2:0]  burst;
    logic [2:0]  size;
    logic        rdy;
    logic        done;
    logic        abort;
    logic        cerr;
  } obs_t;

  obs_t  exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    chk_rst = 1'b0;
  bit    chk_end = 1'b0;
  string tname = "reset";
  logic [2:0] eb = 3'd0;
  logic [2:0] es = 3'd0;

  always @(negedge HCLK) begin
    obs_t got;
    obs_t want;
    got = '{bus.HADDR, bus.HTRANS, bus.beat_idx, bus.HBURST, bus.HSIZE,
            bus.cmd_ready, bus.burst_done, bus.err_abort, bus.cmd_err};
    if (chk_rst) begin
      want = '{32'h0, IDL, 8'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s reset values: got %h want %h", tname, got, want);
      end
    end else if (chk_end) begin
      while (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL %s missing output: got nothing want %h", tname, want);
      end
    end else if (!HRESET && (got.trans != IDL || got.done || got.abort || got.cerr)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL %s unexpected output: got %h want none", tname, got);
      end else begin
        want = exp_q.pop_front();
        if (want.trans == IDL) begin
          got.addr  = '0; got.idx  = '0; got.burst  = '0; got.size  = '0;
          want.addr = '0; want.idx = '0; want.burst = '0; want.size = '0;
        end
        if (got !== want) begin
          n_err++;
          $display("FAIL %s beat: got %h want %h", tname, got, want);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic beat(input logic [31:0] a, input logic [1:0] t, input logic [7:0] i);
    exp_q.push_back('{a, t, i, eb, es, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic fin(input logic d, input logic ab, input logic ce);
    exp_q.push_back('{32'h0, IDL, 8'd0, 3'd0, 3'd0, 1'b1, d, ab, ce});
  endtask

  task automatic issue(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                       input logic [7:0] l);
    bus.cmd_addr  = a;
    bus.cmd_burst = b;
    bus.cmd_size  = s;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_burst = 3'd0;
    bus.cmd_size  = 3'd0;
    bus.cmd_len   = 8'd0;
    bus.busy_req  = 1'b0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
    HRESET = 1'b1;
    step(2);
    chk_rst = 1'b1;
    step(1);
    chk_rst = 1'b0;
    HRESET = 1'b0;
    step(2);

    tname = "wrap4";
    eb = 3'd2; es = 3'd2;
    beat(32'h38, NS, 0); beat(32'h3C, SQ, 1); beat(32'h30, SQ, 2); beat(32'h34, SQ, 3);
    fin(1, 0, 0);
    issue(32'h38, 3'd2, 3'd2, 8'd0);
    step(6);

    tname = "incr_1k";
    eb = 3'd1; es = 3'd1;
    beat(32'h3FC, NS, 0); beat(32'h3FE, SQ, 1); beat(32'h400, NS, 2); beat(32'h402, SQ, 3);
    fin(1, 0, 0);
    issue(32'h3FC, 3'd1, 3'd1, 8'd3);
    step(6);

    tname = "incr8_wait";
    eb = 3'd5; es = 3'd2;
    beat(32'h100, NS, 0); beat(32'h104, SQ, 1);
    beat(32'h108, SQ, 2); beat(32'h108, SQ, 2); beat(32'h108, SQ, 2);
    for (int k = 3; k < 8; k++) beat(32'h100 + 32'(4 * k), SQ, 8'(k));
    fin(1, 0, 0);
    issue(32'h100, 3'd5, 3'd2, 8'd0);
    step(2);
    bus.HREADY = 1'b0;
    step(2);
    bus.HREADY = 1'b1;
    step(10);

    tname = "incr4_busy";
    eb = 3'd3; es = 3'd2;
    beat(32'h0, NS, 0); beat(32'h4, BSY, 1); beat(32'h4, BSY, 1); beat(32'h4, SQ, 1);
    beat(32'h8, SQ, 2); beat(32'hC, SQ, 3);
    fin(1, 0, 0);
    issue(32'h0, 3'd3, 3'd2, 8'd0);
    bus.busy_req = 1'b1;
    step(2);
    bus.busy_req = 1'b0;
    step(7);

    tname = "incr4_edge";
    eb = 3'd3; es = 3'd2;
    beat(32'h3F0, NS, 0); beat(32'h3F4, SQ, 1); beat(32'h3F8, SQ, 2); beat(32'h3FC, SQ, 3);
    fin(1, 0, 0);
    issue(32'h3F0, 3'd3, 3'd2, 8'd0);
    step(6);

    tname = "back2back";
    eb = 3'd0; es = 3'd2;
    beat(32'h40, NS, 0);
    fin(1, 0, 0);
    es = 3'd0;
    beat(32'h81, NS, 0);
    fin(1, 0, 0);
    issue(32'h40, 3'd0, 3'd2, 8'd0);
    bus.cmd_addr  = 32'h81;
    bus.cmd_size  = 3'd0;
    bus.cmd_valid = 1'b1;
    step(2);
    bus.cmd_valid = 1'b0;
    step(3);

    tname = "error_abort";
    eb = 3'd7; es = 3'd2;
    beat(32'h200, NS, 0); beat(32'h204, SQ, 1); beat(32'h208, SQ, 2);
    fin(0, 1, 0);
    issue(32'h200, 3'd7, 3'd2, 8'd0);
    step(2);
    bus.HREADY = 1'b0;
    bus.HRESP  = 1'b1;
    step(1);
    bus.HREADY = 1'b1;
    step(1);
    bus.HRESP  = 1'b0;
    step(3);

    tname = "reset_mid";
    beat(32'h200, NS, 0); beat(32'h204, SQ, 1);
    issue(32'h200, 3'd7, 3'd2, 8'd0);
    step(2);
    HRESET = 1'b1;
    step(1);
    chk_rst = 1'b1;
    step(1);
    chk_rst = 1'b0;
    HRESET = 1'b0;
    step(3);

    tname = "cmd_err";
    fin(0, 0, 1);
    issue(32'h0, 3'd1, 3'd3, 8'd0);
    step(2);
    fin(0, 0, 1);
    issue(32'h3F8, 3'd3, 3'd2, 8'd0);
    step(2);
    fin(0, 0, 1);
    issue(32'h102, 3'd0, 3'd2, 8'd0);
    step(3);

    tname = "end";
    chk_end = 1'b1;
    step(1);
    chk_end = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_burst_addr_gen.md
# ahb_burst_addr_gen

Parametrised AHB master address-phase sequencer for the master agent's active path. Accepts one burst command (start address, HBURST, HSIZE, length) and drives HADDR/HTRANS/HBURST/HSIZE beat by beat, honouring HREADY wait states, BUSY insertion, wrap boundaries, the 1KB boundary rule and two-cycle ERROR aborts. Supports arbitrary ADDR_WIDTH/DATA_WIDTH and undefined-length INCR up to 256 beats; data phase is handled elsewhere.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width (8..1024, power of 2); sets max legal HSIZE = log2(DATA_WIDTH/8)
- BOUNDARY, 1024, byte boundary no burst may cross (power of 2)

- HCLK  in  1  clock
- HRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_burst  in  3  ahb_burst_e encoding
- cmd_size  in  3  HSIZE encoding
- cmd_len  in  8  INCR beats minus 1; ignored for other bursts
- busy_req  in  1  request BUSY before next beat
- HREADY  in  1  combined transfer completion
- HRESP  in  1  0=OKAY, 1=ERROR
- HADDR  out  ADDR_WIDTH  address
- HTRANS  out  2  IDLE/BUSY/NONSEQ/SEQ
- HBURST  out  3  burst type
- HSIZE  out  3  transfer size
- beat_idx  out  8  index of beat currently driven
- burst_done  out  1  pulse: last beat address accepted
- err_abort  out  1  pulse: burst aborted by ERROR
- cmd_err  out  1  pulse: command rejected

## Operation
- States: S_IDLE, S_ADDR, S_BUSY. All outputs registered.
- S_IDLE: HTRANS=IDLE, cmd_ready=1. On cmd_valid: validate; legal -> load regs, beat_idx=0, S_ADDR; illegal -> cmd_err pulse, stay S_IDLE.
- Illegal: cmd_size > log2(DATA_WIDTH/8); cmd_addr not aligned to 2^cmd_size; INCR4/8/16 whose last byte crosses BOUNDARY.
- Beat count: SINGLE 1; WRAP4/INCR4 4; WRAP8/INCR8 8; WRAP16/INCR16 16; INCR cmd_len+1.
- S_ADDR: drives NONSEQ for beat 0, SEQ thereafter. On HREADY=1: if last beat -> burst_done pulse, S_IDLE; else advance address, beat_idx+1; busy_req=1 -> S_BUSY, else stay S_ADDR (SEQ).
- S_BUSY: HTRANS=BUSY, HADDR = next beat's address. On HREADY=1 and busy_req=0 -> S_ADDR, SEQ.
- Next address: inc = 1<<HSIZE. INCRx: addr+inc (modulo 2^ADDR_WIDTH). WRAPn: wb=n*inc; next = (addr & ~(wb-1)) | ((addr+inc) & (wb-1)).
- Undefined INCR crossing BOUNDARY: beat whose address is a multiple of BOUNDARY is driven NONSEQ (HBURST stays INCR); beat count continues.
- ERROR: HRESP=1 and HREADY=0 in S_ADDR/S_BUSY -> next cycle HTRANS=IDLE, err_abort pulse, S_IDLE; remaining beats dropped.
- cmd_ready=0 outside S_IDLE; cmd_valid ignored then.

## Timing
- Reset: HTRANS=IDLE, HADDR=0, HBURST=SINGLE, HSIZE=0, beat_idx=0, cmd_ready=1, burst_done=0, err_abort=0, cmd_err=0, state S_IDLE. Reset mid-burst: outputs take reset values next edge; burst lost, no pulses.
- Command accepted at edge N -> NONSEQ on HADDR in cycle N+1.
- HREADY=0: HADDR/HTRANS/HBURST/HSIZE/beat_idx held unchanged (except ERROR abort).
- Minimum one IDLE cycle between bursts (burst_done cycle returns to S_IDLE; next command accepted there, NONSEQ following cycle).
- burst_done, err_abort, cmd_err: single-cycle, registered, coincide with first IDLE cycle (cmd_err: cycle after cmd_valid sampled).
- ERROR in first cycle of two-cycle response -> IDLE in second cycle.
- busy_req sampled only on HREADY=1 beat completion in S_ADDR, and each HREADY=1 cycle in S_BUSY; ignored on last beat.

## Test plan
- WRAP4, size 2, addr 0x38 -> HADDR 0x38,0x3C,0x30,0x34; HTRANS NONSEQ,SEQ,SEQ,SEQ; burst_done after 4th; then IDLE.
- INCR, cmd_len=3, size 1, addr 0x3FC -> 0x3FC NONSEQ, 0x3FE SEQ, 0x400 NONSEQ, 0x402 SEQ.
- INCR8 size 2 addr 0x100, HREADY=0 for 2 cycles on beat 3 -> HADDR 0x108/SEQ held 3 cycles, beat_idx=2 held, remaining 0x10C..0x11C.
- INCR4 size 2 addr 0x0, busy_req=1 for 2 cycles after beat 0 -> 0x0 NONSEQ, 0x4 BUSY x2, 0x4 SEQ, 0x8, 0xC.
- INCR16 at 0x200, HRESP=1/HREADY=0 on beat 2 -> next cycle HTRANS=IDLE, err_abort=1, cmd_ready=1, no burst_done; reset asserted mid-burst -> all reset values.
- DATA_WIDTH=32: size 3 -> cmd_err, HTRANS stays IDLE; INCR4 size 2 at 0x3F8 -> cmd_err; size 2 at 0x102 -> cmd_err.
